// File: rtl/rij_pkg.sv
// Shared encodings for the RIJ multi-cycle controller: opcodes, functs,
// ALU function codes, mux selects, FSM states and decoder result type.
package rij_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLLV = 6'b000100;

   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_XOR  = 3'b010;
   localparam logic [2:0] ALU_NOR  = 3'b011;
   localparam logic [2:0] ALU_ADD  = 3'b100;
   localparam logic [2:0] ALU_SUB  = 3'b101;
   localparam logic [2:0] ALU_SLT  = 3'b110;
   localparam logic [2:0] ALU_SLLV = 3'b111;

   localparam logic [1:0] ASB_RT   = 2'b00;
   localparam logic [1:0] ASB_SEXT = 2'b01;
   localparam logic [1:0] ASB_ZEXT = 2'b10;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      C_RALU, C_IALU, C_LW, C_SW, C_BR, C_J
   } icls_t;

   typedef struct packed {
      logic [2:0] alu_op;
      logic [1:0] alu_src_b;
      icls_t      cls;
      logic       bne;
      logic       ovf_chk;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/rij_alu_dec.sv
// Combinational instruction decoder: opcode/funct to ALU function, operand-B
// select, instruction class, overflow-check enable and illegal flag.
module rij_alu_dec
   import rij_pkg::*;
(
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   output dec_t       dec_o
);

   always_comb begin
      dec_o           = '0;
      dec_o.cls       = C_RALU;
      dec_o.alu_op    = ALU_AND;
      dec_o.alu_src_b = ASB_RT;
      dec_o.illegal   = 1'b1;
      unique case (opcode_i)
         OP_RTYPE: begin
            dec_o.cls     = C_RALU;
            dec_o.illegal = 1'b0;
            unique case (funct_i)
               FN_ADD:  begin dec_o.alu_op = ALU_ADD; dec_o.ovf_chk = 1'b1; end
               FN_SUB:  begin dec_o.alu_op = ALU_SUB; dec_o.ovf_chk = 1'b1; end
               FN_AND:  dec_o.alu_op = ALU_AND;
               FN_OR:   dec_o.alu_op = ALU_OR;
               FN_XOR:  dec_o.alu_op = ALU_XOR;
               FN_NOR:  dec_o.alu_op = ALU_NOR;
               FN_SLT:  dec_o.alu_op = ALU_SLT;
               FN_SLLV: dec_o.alu_op = ALU_SLLV;
               default: dec_o.illegal = 1'b1;
            endcase
         end
         OP_ADDI: begin
            dec_o = '{ALU_ADD, ASB_SEXT, C_IALU, 1'b0, 1'b1, 1'b0};
         end
         OP_SLTI: dec_o = '{ALU_SLT, ASB_SEXT, C_IALU, 1'b0, 1'b0, 1'b0};
         OP_ANDI: dec_o = '{ALU_AND, ASB_ZEXT, C_IALU, 1'b0, 1'b0, 1'b0};
         OP_ORI:  dec_o = '{ALU_OR,  ASB_ZEXT, C_IALU, 1'b0, 1'b0, 1'b0};
         OP_XORI: dec_o = '{ALU_XOR, ASB_ZEXT, C_IALU, 1'b0, 1'b0, 1'b0};
         OP_LW:   dec_o = '{ALU_ADD, ASB_SEXT, C_LW,   1'b0, 1'b0, 1'b0};
         OP_SW:   dec_o = '{ALU_ADD, ASB_SEXT, C_SW,   1'b0, 1'b0, 1'b0};
         OP_BEQ:  dec_o = '{ALU_SUB, ASB_RT,   C_BR,   1'b0, 1'b0, 1'b0};
         OP_BNE:  dec_o = '{ALU_SUB, ASB_RT,   C_BR,   1'b1, 1'b0, 1'b0};
         OP_J:    dec_o = '{ALU_AND, ASB_RT,   C_J,    1'b0, 1'b0, 1'b0};
         default: ;
      endcase
   end

endmodule

// File: rtl/rij_mc_ctrl.sv
// RIJ multi-cycle control unit: IF/ID/EX/MEM/WB sequencer, one instruction in
// flight. Control outputs are decoded from state and IR fields; flags are sticky.
module rij_mc_ctrl
   import rij_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zf,
   input  logic             of,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             ir_write,
   output logic [2:0]       alu_op,
   output logic [1:0]       alu_src_b,
   output logic             aluout_write,
   output logic             mem_write,
   output logic             mdr_write,
   output logic             reg_dst,
   output logic             wb_src,
   output logic             reg_write,
   output logic             busy,
   output logic             instr_done,
   output logic             ovf_exc,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   state_t             state_q, state_d;
   logic               ovf_pending_q, ovf_exc_q, illegal_q;
   logic [CNT_W-1:0]   retired_q;
   logic               retire;
   dec_t               dec;

   rij_alu_dec u_dec (
      .opcode_i (opcode),
      .funct_i  (funct),
      .dec_o    (dec)
   );

   always_comb begin
      state_d      = state_q;
      retire       = 1'b0;
      pc_write     = 1'b0;
      pc_src       = PC_SEQ;
      ir_write     = 1'b0;
      alu_op       = ALU_AND;
      alu_src_b    = ASB_RT;
      aluout_write = 1'b0;
      mem_write    = 1'b0;
      mdr_write    = 1'b0;
      reg_dst      = 1'b0;
      wb_src       = 1'b0;
      reg_write    = 1'b0;
      unique case (state_q)
         S_IDLE: if (run) state_d = S_IF;
         S_IF: begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_ID;
         end
         S_ID: begin
            if (dec.illegal) begin
               state_d = S_HALT;
            end else if (dec.cls == C_J) begin
               pc_write = 1'b1;
               pc_src   = PC_JMP;
               retire   = 1'b1;
            end else begin
               state_d = S_EX;
            end
         end
         S_EX: begin
            alu_op    = dec.alu_op;
            alu_src_b = dec.alu_src_b;
            if (dec.cls == C_BR) begin
               pc_write = dec.bne ? ~zf : zf;
               pc_src   = PC_BR;
               retire   = 1'b1;
            end else begin
               aluout_write = 1'b1;
               state_d = (dec.cls == C_LW || dec.cls == C_SW) ? S_MEM : S_WB;
            end
         end
         S_MEM: begin
            if (dec.cls == C_SW) begin
               mem_write = 1'b1;
               retire    = 1'b1;
            end else begin
               mdr_write = 1'b1;
               state_d   = S_WB;
            end
         end
         S_WB: begin
            reg_write = ~ovf_pending_q;
            reg_dst   = (dec.cls == C_RALU);
            wb_src    = (dec.cls == C_LW);
            retire    = 1'b1;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
      // Retire point doubles as the instruction boundary where run is sampled.
      if (retire) state_d = run ? S_IF : S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         ovf_pending_q <= 1'b0;
         ovf_exc_q     <= 1'b0;
         illegal_q     <= 1'b0;
         retired_q     <= '0;
      end else begin
         state_q <= state_d;
         if (retire) retired_q <= retired_q + CNT_W'(1);
         if (state_q == S_EX) begin
            ovf_pending_q <= dec.ovf_chk & of;
            ovf_exc_q     <= ovf_exc_q | (dec.ovf_chk & of);
         end
         if (state_q == S_ID && dec.illegal) illegal_q <= 1'b1;
      end
   end

   assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
   assign instr_done = retire;
   assign ovf_exc    = ovf_exc_q;
   assign illegal    = illegal_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_rij_mc_ctrl.sv
// Scoreboard bench for rij_mc_ctrl: per-instruction expected control words are
// queued when the instruction is presented and compared cycle by cycle.
module tb_rij_mc_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, run, zf, of;
   logic [5:0]  opcode, funct;
   logic        pc_write, ir_write, aluout_write, mem_write, mdr_write;
   logic        reg_dst, wb_src, reg_write, busy, instr_done, ovf_exc, illegal;
   logic [1:0]  pc_src, alu_src_b;
   logic [2:0]  alu_op;
   logic [31:0] retired;

   int errs = 0;
   int checks = 0;
   logic [15:0] exp_q[$];
   int   exp_ret = 0;
   logic exp_ovf = 1'b0;

   rij_mc_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct(funct),
      .zf(zf), .of(of), .pc_write(pc_write), .pc_src(pc_src),
      .ir_write(ir_write), .alu_op(alu_op), .alu_src_b(alu_src_b),
      .aluout_write(aluout_write), .mem_write(mem_write), .mdr_write(mdr_write),
      .reg_dst(reg_dst), .wb_src(wb_src), .reg_write(reg_write), .busy(busy),
      .instr_done(instr_done), .ovf_exc(ovf_exc), .illegal(illegal),
      .retired(retired)
   );

   always #5 clk = ~clk;

   wire [15:0] cw = {pc_write, pc_src, ir_write, alu_op, alu_src_b, aluout_write,
                     mem_write, mdr_write, reg_dst, wb_src, reg_write, instr_done};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] mk(input logic pcw, input logic [1:0] pcs,
         input logic irw, input logic [2:0] aop, input logic [1:0] asb,
         input logic aow, input logic mw, input logic mdrw, input logic rd,
         input logic wbs, input logic rw, input logic dn);
      return {pcw, pcs, irw, aop, asb, aow, mw, mdrw, rd, wbs, rw, dn};
   endfunction

   // k: 0 R-ALU, 1 I-ALU, 2 lw, 3 sw, 4 beq, 5 bne, 6 j, 7 illegal
   task automatic push_exp(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic o);
      int k = 7;
      logic [2:0] aop = 3'd0;
      logic [1:0] asb = 2'd0;
      logic cov = 1'b0;
      logic ovf;
      case (op)
         6'h00: begin
            k = 0;
            case (fn)
               6'h20: begin aop = 3'd4; cov = 1'b1; end
               6'h22: begin aop = 3'd5; cov = 1'b1; end
               6'h24: aop = 3'd0;
               6'h25: aop = 3'd1;
               6'h26: aop = 3'd2;
               6'h27: aop = 3'd3;
               6'h2a: aop = 3'd6;
               6'h04: aop = 3'd7;
               default: k = 7;
            endcase
         end
         6'h08: begin k = 1; aop = 3'd4; asb = 2'd1; cov = 1'b1; end
         6'h0a: begin k = 1; aop = 3'd6; asb = 2'd1; end
         6'h0c: begin k = 1; aop = 3'd0; asb = 2'd2; end
         6'h0d: begin k = 1; aop = 3'd1; asb = 2'd2; end
         6'h0e: begin k = 1; aop = 3'd2; asb = 2'd2; end
         6'h23: begin k = 2; aop = 3'd4; asb = 2'd1; end
         6'h2b: begin k = 3; aop = 3'd4; asb = 2'd1; end
         6'h04: begin k = 4; aop = 3'd5; end
         6'h05: begin k = 5; aop = 3'd5; end
         6'h02: k = 6;
         default: k = 7;
      endcase
      ovf = cov & o;
      exp_q.push_back(mk(1, 2'd0, 1, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
      if (k == 7) begin
         exp_q.push_back(16'h0);
         return;
      end
      exp_ret++;
      if (k == 6) begin
         exp_q.push_back(mk(1, 2'd2, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1));
         return;
      end
      exp_q.push_back(16'h0);
      if (k == 4 || k == 5) begin
         exp_q.push_back(mk((k == 4) ? z : ~z, 2'd1, 0, aop, asb, 0, 0, 0, 0, 0, 0, 1));
         return;
      end
      exp_q.push_back(mk(0, 2'd0, 0, aop, asb, 1, 0, 0, 0, 0, 0, 0));
      exp_ovf = exp_ovf | ovf;
      if (k == 3) begin
         exp_q.push_back(mk(0, 2'd0, 0, 3'd0, 2'd0, 0, 1, 0, 0, 0, 0, 1));
      end else if (k == 2) begin
         exp_q.push_back(mk(0, 2'd0, 0, 3'd0, 2'd0, 0, 0, 1, 0, 0, 0, 0));
         exp_q.push_back(mk(0, 2'd0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 1, 1, 1));
      end else begin
         exp_q.push_back(mk(0, 2'd0, 0, 3'd0, 2'd0, 0, 0, 0, (k == 0), 0, ~ovf, 1));
      end
   endtask

   // Called with the DUT in IF, sampled 1 time unit after the edge.
   task automatic exec(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic o, input bit drop_run);
      logic [15:0] e;
      int n = 0;
      opcode = op; funct = fn; zf = z; of = o;
      push_exp(op, fn, z, o);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk($sformatf("cw op%0h fn%0h cyc%0d", op, fn, n), {16'h0, cw}, {16'h0, e});
         chk($sformatf("busy op%0h cyc%0d", op, n), {31'h0, busy}, 32'd1);
         if (drop_run && n == 2) run = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      chk($sformatf("retired op%0h", op), retired, exp_ret);
      chk($sformatf("ovf_exc op%0h", op), {31'h0, ovf_exc}, {31'h0, exp_ovf});
   endtask

   logic [5:0] alu_ops[11] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                               6'h08, 6'h0a, 6'h0c, 6'h0e, 6'h00};
   logic [5:0] alu_fns[11] = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h04,
                               6'h00, 6'h00, 6'h00, 6'h00, 6'h20};
   logic       alu_ofs[11] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 0, 0};

   initial begin
      rst_n = 1'b0; run = 1'b0; opcode = 6'h0; funct = 6'h0; zf = 1'b0; of = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk("rst cw", {16'h0, cw}, 32'h0);
      chk("rst busy", {31'h0, busy}, 32'h0);
      chk("rst flags", {30'h0, ovf_exc, illegal}, 32'h0);
      chk("rst retired", retired, 32'h0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk); #1;
      chk("idle cw", {16'h0, cw}, 32'h0);
      chk("idle busy", {31'h0, busy}, 32'h0);

      run = 1'b1;
      @(posedge clk); #1;
      exec(6'h00, 6'h20, 1'b0, 1'b0, 1'b0);           // add
      exec(6'h00, 6'h22, 1'b0, 1'b1, 1'b0);           // sub overflows
      exec(6'h04, 6'h00, 1'b1, 1'b0, 1'b0);           // beq taken
      exec(6'h05, 6'h00, 1'b1, 1'b0, 1'b0);           // bne not taken
      exec(6'h05, 6'h00, 1'b0, 1'b1, 1'b0);           // bne taken, OF ignored
      exec(6'h04, 6'h00, 1'b0, 1'b0, 1'b0);           // beq not taken
      exec(6'h23, 6'h00, 1'b0, 1'b1, 1'b0);           // lw, OF ignored
      exec(6'h2b, 6'h00, 1'b0, 1'b1, 1'b0);           // sw
      exec(6'h02, 6'h00, 1'b0, 1'b0, 1'b0);           // j
      for (int i = 0; i < 11; i++)
         exec(alu_ops[i], alu_fns[i], 1'b0, alu_ofs[i], 1'b0);

      exec(6'h0d, 6'h00, 1'b0, 1'b0, 1'b1);           // ori, run dropped in EX
      chk("stop busy", {31'h0, busy}, 32'h0);
      repeat (2) @(posedge clk); #1;
      chk("stop cw", {16'h0, cw}, 32'h0);
      chk("stop retired", retired, exp_ret);

      opcode = 6'h00; funct = 6'h20; of = 1'b0;
      run = 1'b1;
      repeat (3) @(posedge clk); #1;
      chk("pre-rst EX aluout", {31'h0, aluout_write}, 32'd1);
      rst_n = 1'b0; run = 1'b0;
      #1;
      chk("midrst cw", {16'h0, cw}, 32'h0);
      chk("midrst busy", {31'h0, busy}, 32'h0);
      chk("midrst retired", retired, 32'h0);
      chk("midrst ovf", {31'h0, ovf_exc}, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk); #1;
      chk("postrst reg_write", {31'h0, reg_write}, 32'h0);
      exp_ret = 0; exp_ovf = 1'b0;

      run = 1'b1;
      @(posedge clk); #1;
      exec(6'h3f, 6'h00, 1'b0, 1'b0, 1'b0);           // undefined opcode
      for (int i = 0; i < 4; i++) begin
         chk("halt illegal", {31'h0, illegal}, 32'd1);
         chk("halt busy", {31'h0, busy}, 32'h0);
         chk("halt cw", {16'h0, cw}, 32'h0);
         @(posedge clk); #1;
      end
      rst_n = 1'b0; #1;
      chk("halt reset illegal", {31'h0, illegal}, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      exec(6'h00, 6'h3f, 1'b0, 1'b0, 1'b0);           // undefined funct
      chk("funct illegal", {31'h0, illegal}, 32'd1);
      chk("funct busy", {31'h0, busy}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
